// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared opcodes, PC select encodings, sequencer states and uses_rt helper
package pipeline_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam logic [1:0] PC_SEL_SEQ = 2'b00;
  localparam logic [1:0] PC_SEL_BR  = 2'b01;
  localparam logic [1:0] PC_SEL_JMP = 2'b10;

  typedef enum logic [1:0] {
    ARRANQUE   = 2'b00,
    RUN        = 2'b01,
    ESPERA_MEM = 2'b10
  } estado_t;

  // Opcodes whose rt field is a source operand rather than a destination
  function automatic logic uses_rt(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ);
  endfunction

endpackage

// File: rtl/detector_carga_uso.sv
// rtl/detector_carga_uso.sv - combinational load-use hazard comparator between EX load and ID sources
module detector_carga_uso
  import pipeline_pkg::*;
(
  input  logic [5:0] id_op,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       ex_LeerMem,
  input  logic [4:0] ex_rt,
  output logic       hazard
);

  // Register 0 is hardwired, so a load into it never creates a dependency
  assign hazard = ex_LeerMem && (ex_rt != 5'd0) &&
                  ((ex_rt == id_rs) || (uses_rt(id_op) && (ex_rt == id_rt)));

endmodule

// File: rtl/control_riesgos.sv
// rtl/control_riesgos.sv - pipeline sequencer: start-up bubbles, memory waits, branch/jump flush, load-use stall
module control_riesgos
  import pipeline_pkg::*;
#(
  parameter int CNT_W         = 16,
  parameter int RESET_BUBBLES = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       id_op,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_Saltoincond,
  input  logic             ex_LeerMem,
  input  logic [4:0]       ex_rt,
  input  logic             ex_SaltoCond,
  input  logic             ex_zero,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic [1:0]       pc_sel,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int BOOT_W = (RESET_BUBBLES > 1) ? $clog2(RESET_BUBBLES + 1) : 1;
  localparam logic [BOOT_W-1:0] BOOT_INIT = BOOT_W'(RESET_BUBBLES);

  estado_t           state, next_state;
  logic [BOOT_W-1:0] boot_cnt;
  logic              hazard;
  logic              mem_wait;
  logic              advance;
  logic              stall_inc;
  logic              flush_inc;

  detector_carga_uso u_detector (
    .id_op      (id_op),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .ex_LeerMem (ex_LeerMem),
    .ex_rt      (ex_rt),
    .hazard     (hazard)
  );

  // mem_ready only has meaning while an access is outstanding
  assign mem_wait = mem_req && !mem_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ARRANQUE;
      boot_cnt <= BOOT_INIT;
    end else begin
      state <= next_state;
      if (state == ARRANQUE) boot_cnt <= boot_cnt - BOOT_W'(1);
    end
  end

  always_comb begin
    next_state = state;
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    idex_en    = 1'b1;
    exmem_en   = 1'b1;
    memwb_en   = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    pc_sel     = PC_SEL_SEQ;
    stall_inc  = 1'b0;
    flush_inc  = 1'b0;
    advance    = 1'b0;

    case (state)
      ARRANQUE: begin
        pc_en      = 1'b0;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        if (boot_cnt == BOOT_W'(1)) next_state = RUN;
      end
      RUN: begin
        if (mem_wait) next_state = ESPERA_MEM;
        else          advance    = 1'b1;
      end
      ESPERA_MEM: begin
        if (!mem_wait) begin
          advance    = 1'b1;
          next_state = RUN;
        end
      end
      default: next_state = ARRANQUE;
    endcase

    if ((state != ARRANQUE) && mem_wait) begin
      pc_en     = 1'b0;
      ifid_en   = 1'b0;
      idex_en   = 1'b0;
      exmem_en  = 1'b0;
      memwb_en  = 1'b0;
      stall_inc = 1'b1;
    end

    // Branch beats jump beats load-use; only one response per cycle
    if (advance) begin
      if (ex_SaltoCond && ex_zero) begin
        pc_sel     = PC_SEL_BR;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        flush_inc  = 1'b1;
      end else if (id_Saltoincond) begin
        pc_sel     = PC_SEL_JMP;
        ifid_flush = 1'b1;
        flush_inc  = 1'b1;
      end else if (hazard) begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
        stall_inc  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_inc && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_inc && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_control_riesgos.sv
// tb/tb_control_riesgos.sv - directed vector bench for control_riesgos (CNT_W=4, RESET_BUBBLES=3)
module tb_control_riesgos;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [5:0]    id_op = '0;
  logic [4:0]    id_rs = '0, id_rt = '0, ex_rt = '0;
  logic          id_Saltoincond = 1'b0, ex_LeerMem = 1'b0, ex_SaltoCond = 1'b0, ex_zero = 1'b0;
  logic          mem_req = 1'b0, mem_ready = 1'b0;
  logic          pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush;
  logic [1:0]    pc_sel;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;
  int exp_s  = 0;
  int exp_f  = 0;

  always #5 clk = ~clk;

  control_riesgos #(.CNT_W(CW), .RESET_BUBBLES(3)) dut (
    .clk(clk), .rst_n(rst_n), .id_op(id_op), .id_rs(id_rs), .id_rt(id_rt),
    .id_Saltoincond(id_Saltoincond), .ex_LeerMem(ex_LeerMem), .ex_rt(ex_rt),
    .ex_SaltoCond(ex_SaltoCond), .ex_zero(ex_zero), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .pc_sel(pc_sel),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  typedef struct {
    logic [5:0] op;
    logic [4:0] rs, rt;
    logic       jmp, ld;
    logic [4:0] ert;
    logic       br, zero;
    logic       pe, fe, ff, xf;
    logic [1:0] sel;
    logic       si, fi;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int enables();
    return {27'd0, pc_en, ifid_en, idex_en, exmem_en, memwb_en};
  endfunction

  task automatic idle();
    id_op = '0; id_rs = '0; id_rt = '0; id_Saltoincond = 0; ex_LeerMem = 0; ex_rt = '0;
    ex_SaltoCond = 0; ex_zero = 0; mem_req = 0; mem_ready = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_arranque(input string tag);
    chk({tag, "_pc_en"}, int'(pc_en), 0);
    chk({tag, "_flushes"}, int'({ifid_flush, idex_flush}), 3);
    chk({tag, "_other_en"}, int'({ifid_en, idex_en, exmem_en, memwb_en}), 15);
    chk({tag, "_pc_sel"}, int'(pc_sel), 0);
  endtask

  task automatic boot_sequence(input string tag);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      check_arranque($sformatf("%s_bubble%0d", tag, k));
      tick();
    end
    chk({tag, "_run_en"}, enables(), 31);
    chk({tag, "_run_flush"}, int'({ifid_flush, idex_flush}), 0);
    chk({tag, "_stall_cnt"}, int'(stall_cnt), 0);
    chk({tag, "_flush_cnt"}, int'(flush_cnt), 0);
  endtask

  initial begin
    vecs[0]  = '{6'o00, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
    vecs[1]  = '{6'b000000, 5'd1, 5'd5, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0};
    vecs[2]  = '{6'b000000, 5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
    vecs[3]  = '{6'b100011, 5'd7, 5'd3, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0};
    vecs[4]  = '{6'b100011, 5'd3, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
    vecs[5]  = '{6'b101011, 5'd3, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0};
    vecs[6]  = '{6'b000100, 5'd3, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0};
    vecs[7]  = '{6'b000000, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'd1, 1'b0, 1'b1};
    vecs[8]  = '{6'b000000, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
    vecs[9]  = '{6'b000000, 5'd1, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'd1, 1'b0, 1'b1};
    vecs[10] = '{6'b000000, 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1};
    vecs[11] = '{6'b000000, 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'd1, 1'b0, 1'b1};
    vecs[12] = '{6'b000000, 5'd5, 5'd2, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1};
    vecs[13] = '{6'b000000, 5'd5, 5'd5, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};

    idle();
    #12;
    check_arranque("in_reset");
    chk("in_reset_stall_cnt", int'(stall_cnt), 0);
    boot_sequence("boot");

    for (int i = 0; i < 14; i++) begin
      id_op = vecs[i].op; id_rs = vecs[i].rs; id_rt = vecs[i].rt;
      id_Saltoincond = vecs[i].jmp; ex_LeerMem = vecs[i].ld; ex_rt = vecs[i].ert;
      ex_SaltoCond = vecs[i].br; ex_zero = vecs[i].zero;
      #1;
      chk($sformatf("v%0d_pc_en", i), int'(pc_en), int'(vecs[i].pe));
      chk($sformatf("v%0d_ifid_en", i), int'(ifid_en), int'(vecs[i].fe));
      chk($sformatf("v%0d_back_en", i), int'({idex_en, exmem_en, memwb_en}), 7);
      chk($sformatf("v%0d_ifid_flush", i), int'(ifid_flush), int'(vecs[i].ff));
      chk($sformatf("v%0d_idex_flush", i), int'(idex_flush), int'(vecs[i].xf));
      chk($sformatf("v%0d_pc_sel", i), int'(pc_sel), int'(vecs[i].sel));
      exp_s += int'(vecs[i].si);
      exp_f += int'(vecs[i].fi);
      tick();
      chk($sformatf("v%0d_stall_cnt", i), int'(stall_cnt), exp_s);
      chk($sformatf("v%0d_flush_cnt", i), int'(flush_cnt), exp_f);
    end
    idle();

    // Memory wait of 4 cycles with a pending jump that must stay masked
    mem_req = 1; mem_ready = 0; id_Saltoincond = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("wait%0d_en", k), enables(), 0);
      chk($sformatf("wait%0d_pc_sel", k), int'(pc_sel), 0);
      chk($sformatf("wait%0d_flush", k), int'({ifid_flush, idex_flush}), 0);
      tick();
    end
    mem_ready = 1;
    #1;
    chk("wait_done_en", enables(), 31);
    chk("wait_done_pc_sel", int'(pc_sel), 2);
    chk("wait_done_ifid_flush", int'(ifid_flush), 1);
    tick();
    exp_s += 4; exp_f += 1;
    chk("wait_stall_cnt", int'(stall_cnt), exp_s);
    chk("wait_flush_cnt", int'(flush_cnt), exp_f);
    idle();
    ex_LeerMem = 1; ex_rt = 5'd4; id_rs = 5'd4;
    #1;
    chk("after_wait_hazard_pc_en", int'(pc_en), 0);
    chk("after_wait_hazard_flush", int'(idex_flush), 1);
    tick();
    exp_s += 1;
    chk("after_wait_stall_cnt", int'(stall_cnt), exp_s);
    idle();

    // Saturation of both counters at 15
    mem_req = 1;
    for (int k = 0; k < 8; k++) tick();
    chk("stall_cnt_sat", int'(stall_cnt), 15);
    mem_ready = 1;
    tick();
    idle();
    id_Saltoincond = 1;
    for (int k = 0; k < 12; k++) tick();
    chk("flush_cnt_sat", int'(flush_cnt), 15);
    chk("stall_cnt_hold", int'(stall_cnt), 15);
    idle();

    // Asynchronous reset in the middle of a memory wait
    mem_req = 1;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_arranque("async_rst");
    chk("async_rst_stall_cnt", int'(stall_cnt), 0);
    chk("async_rst_flush_cnt", int'(flush_cnt), 0);
    mem_req = 0;
    boot_sequence("reboot");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete, expected finish before %0t", $time);
    $fatal(1);
  end

endmodule

// File: doc/control_riesgos.md
# control_riesgos

Pipeline sequencing unit for the five-stage processor: it owns the pipeline register enables and flushes and the PC source select. It resolves load-use hazards, taken conditional branches, unconditional jumps and data-memory wait states, and it inserts start-up bubbles after reset. It sits beside the main control decoder and consumes decoded control bits from the ID, EX and MEM stages. It also keeps saturating stall and flush counters for performance debug.

## Interface
- CNT_W, 16, width of stall_cnt and flush_cnt.
- RESET_BUBBLES, 3, cycles in start-up state after reset release (≥1).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- id_op  in  6  opcode of the instruction in ID.
- id_rs, id_rt  in  5 each  source register fields in ID.
- id_Saltoincond  in  1  unconditional jump decoded in ID.
- ex_LeerMem  in  1  instruction in EX is a load.
- ex_rt  in  5  load destination register in EX.
- ex_SaltoCond, ex_zero  in  1 each  conditional branch in EX, and the ALU zero flag.
- mem_req  in  1  MEM stage performs LeerMem or EscrMem this cycle.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  stage register enables.
- ifid_flush, idex_flush  out  1 each  load a bubble (all control bits 0) into IF/ID or ID/EX.
- pc_sel  out  2  00 = PC+4, 01 = branch target, 10 = jump target, 11 = unused.
- stall_cnt, flush_cnt  out  CNT_W each  saturating event counters.

## Operation
- FSM states: ARRANQUE, RUN, ESPERA_MEM. Outputs are Mealy, a function of state and current inputs.
- ARRANQUE: pc_en=0, ifid_flush=1, idex_flush=1, all other enables 1, pc_sel=00.
  - Down-counter loaded with RESET_BUBBLES at reset, decremented each cycle.
  - Move to RUN on the cycle the counter equals 1.
- RUN uses fixed priority. The first matching case sets the outputs; defaults are all enables 1, flushes 0, pc_sel=00.
  1. mem_req & !mem_ready: all five enables 0, flushes 0; stall_cnt+1; next state ESPERA_MEM.
  2. ex_SaltoCond & ex_zero: pc_sel=01, ifid_flush=1, idex_flush=1; flush_cnt+1.
  3. id_Saltoincond: pc_sel=10, ifid_flush=1; flush_cnt+1.
  4. Load-use hazard: pc_en=0, ifid_en=0, idex_flush=1; stall_cnt+1.
- Load-use hazard condition: ex_LeerMem & ex_rt≠0 & (ex_rt==id_rs | (uses_rt(id_op) & ex_rt==id_rt)).
  - uses_rt is 1 for opcodes 000000, 101011 and 000100; 0 otherwise.
- ESPERA_MEM:
  - While mem_ready=0: all enables 0 and stall_cnt+1.
  - On mem_ready=1: that cycle evaluates RUN priorities 2–4 (the pipeline advances), and the next state is RUN.
- mem_ready is ignored whenever mem_req=0.
- Counters saturate at 2^CNT_W−1 and never wrap.
  - Events that coincide in one cycle increment each counter by at most 1.

## Timing
- Reset assertion acts immediately, without waiting for a clock edge:
  - state=ARRANQUE; outputs take ARRANQUE values (pc_en=0, ifid_flush=1, idex_flush=1, pc_sel=00).
  - Counters reset to 0.
- Hazard, branch and jump responses are combinational, in the same cycle as the triggering inputs. No added latency.
- The FSM state and the counters update on the next rising edge; counter values are visible one cycle after the event.
- Reset asserted during ESPERA_MEM abandons the wait and returns to ARRANQUE. The memory must tolerate the dropped request.
- A branch in EX while a load-use hazard exists in ID: the flush wins and the stall is not counted.
- Branch in EX and jump in ID in the same cycle: branch wins and flush_cnt increments once.
- A memory wait masks every lower-priority event until the cycle in which mem_ready=1.

## Structure
- Shared package pipeline_pkg holds:
  - opcode constants OP_RTYPE=000000, OP_LW=100011, OP_SW=101011, OP_BEQ=000100;
  - PC_SEL_SEQ/BR/JMP encodings;
  - the FSM state enum;
  - the uses_rt function.
- One natural sub-module: detector_carga_uso, a purely combinational load-use comparator producing a 1-bit hazard flag.
- The FSM, priority mux and counters live in the top module.

## Test plan
- Reset release with RESET_BUBBLES=3 -> pc_en=0 with both flushes 1 for exactly 3 cycles, then pc_en=1 and counters 0.
- ex_LeerMem=1, ex_rt=5, id_op=000000, id_rt=5 -> one cycle with pc_en=0, ifid_en=0, idex_flush=1; stall_cnt goes from 0 to 1. Repeat with ex_rt=0 -> no stall.
- ex_SaltoCond=1, ex_zero=1 together with a load-use hazard -> pc_sel=01, both flushes 1, pc_en=1; flush_cnt+1, stall_cnt unchanged.
- mem_req=1 with mem_ready=0 for 4 cycles, then 1 -> all enables 0 for 4 cycles, advance on the 5th; stall_cnt=4; state returns to RUN.
- Force stall_cnt to all-ones with CNT_W=4, then add one more stall -> stall_cnt stays 15.
- Assert rst_n=0 mid-ESPERA_MEM -> outputs take ARRANQUE values immediately (before the next clock edge) and counters clear.
